// File: rtl/pipeline_hold_ctrl_if.sv
// Control bundle between the pipeline (master: stall/flush sources, register
// enables) and pipeline_hold_ctrl (slave: per-stage hold/bubble generation).
interface pipeline_hold_ctrl_if #(
  parameter int NUM_SRC = 3,
  parameter int STAGES  = 5,
  parameter int CNT_W   = 32
);
  logic [NUM_SRC-1:0] stall_req;
  logic               flush_req;
  logic               cnt_clr;
  logic [STAGES-1:0]  stall_o;
  logic [STAGES-1:0]  bubble_o;
  logic               stall;
  logic               flush_busy;
  logic [CNT_W-1:0]   stall_cnt;
  logic               timeout_o;

  modport master (
    output stall_req, flush_req, cnt_clr,
    input  stall_o, bubble_o, stall, flush_busy, stall_cnt, timeout_o
  );

  modport slave (
    input  stall_req, flush_req, cnt_clr,
    output stall_o, bubble_o, stall, flush_busy, stall_cnt, timeout_o
  );
endinterface

// File: rtl/pipeline_hold_ctrl.sv
// Per-stage hold/bubble controller: maps stall sources onto stage holds,
// sequences multi-cycle front-end flushes, counts stall cycles, runs a watchdog.
module pipeline_hold_ctrl #(
  parameter int                   NUM_SRC      = 3,
  parameter int                   STAGES       = 5,
  parameter logic [NUM_SRC*8-1:0] SRC_STAGE    = {8'd3, 8'd1, 8'd1},
  parameter int                   FLUSH_DEPTH  = 2,
  parameter int                   FLUSH_CYCLES = 1,
  parameter int                   CNT_W        = 32,
  parameter int                   TIMEOUT      = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_hold_ctrl_if.slave  bus
);

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam int RW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [FCW-1:0] FC_L  = FCW'(FLUSH_CYCLES);
  localparam logic [RW-1:0]  TO_L  = RW'(TIMEOUT);
  localparam bit             WD_EN = (TIMEOUT > 0);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]       st, st_n;
  logic             pend, pend_n;
  logic [FCW-1:0]   fcnt, fcnt_n;
  logic [RW-1:0]    run_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             timeout;

  logic [STAGES-1:0] hold, sbub, fmask, fgate, stall_o_c, bubble_c;
  logic              any_stall, flushing, stall_c, req;

  // A source owning stage k holds every stage upstream of it as well.
  always_comb begin
    hold = '0;
    for (int s = 0; s < STAGES; s++)
      for (int i = 0; i < NUM_SRC; i++)
        if (int'(SRC_STAGE[8*i +: 8]) >= s) hold[s] = hold[s] | bus.stall_req[i];
  end

  assign sbub[0] = 1'b0;
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    assign fmask[s] = (s < FLUSH_DEPTH);
    if (s > 0) begin : g_bub
      assign sbub[s] = hold[s-1] & ~hold[s];
    end
  end

  assign any_stall = |bus.stall_req;
  assign req       = bus.flush_req;
  assign flushing  = (st == FLUSH);
  assign fgate     = flushing ? fmask : '0;
  assign stall_o_c = hold & ~fgate;
  assign bubble_c  = sbub | fgate;
  assign stall_c   = |stall_o_c;

  assign bus.stall_o    = rst_n ? stall_o_c : '0;
  assign bus.bubble_o   = rst_n ? bubble_c  : '0;
  assign bus.stall      = rst_n & stall_c;
  assign bus.flush_busy = rst_n & (pend | flushing);
  assign bus.stall_cnt  = stall_cnt;
  assign bus.timeout_o  = timeout;

  always_comb begin
    st_n   = st;
    pend_n = pend;
    fcnt_n = fcnt;
    case (st)
      RUN: begin
        if (any_stall) begin
          st_n   = STALL;
          pend_n = pend | req;
        end else if (pend | req) begin
          st_n   = FLUSH;
          pend_n = 1'b1;
          fcnt_n = FC_L;
        end
      end
      STALL: begin
        pend_n = pend | req;
        if (!any_stall) begin
          if (pend | req) begin
            st_n = FLUSH;
            // Resume an interrupted flush; a fresh one starts full length.
            if (fcnt == '0) fcnt_n = FC_L;
          end else begin
            st_n = RUN;
          end
        end
      end
      FLUSH: begin
        if (req) begin
          fcnt_n = FC_L;
          pend_n = 1'b1;
        end else if (fcnt <= 1) begin
          fcnt_n = '0;
          pend_n = 1'b0;
        end else begin
          fcnt_n = fcnt - 1'b1;
        end
        if (any_stall)                 st_n = STALL;
        else if (!req && fcnt <= 1)    st_n = RUN;
      end
      default: begin
        st_n   = RUN;
        pend_n = 1'b0;
        fcnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= RUN;
      pend <= 1'b0;
      fcnt <= '0;
    end else begin
      st   <= st_n;
      pend <= pend_n;
      fcnt <= fcnt_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      run_cnt   <= '0;
      timeout   <= 1'b0;
    end else begin
      if (bus.cnt_clr)                        stall_cnt <= '0;
      else if (stall_c && stall_cnt != '1)    stall_cnt <= stall_cnt + 1'b1;

      if (!stall_c)                           run_cnt <= '0;
      else if (run_cnt != TO_L)               run_cnt <= run_cnt + 1'b1;

      // Fires on the stall cycle that brings the run length to TIMEOUT.
      if (bus.cnt_clr)                                            timeout <= 1'b0;
      else if (WD_EN && stall_c && run_cnt >= TO_L - 1'b1)        timeout <= 1'b1;
    end
  end

endmodule

// File: doc/pipeline_hold_ctrl.md
# pipeline_hold_ctrl

Parametrised hazard and hold controller for the Buraq-mini pipeline. It replaces the single OR-ed `stall` with per-stage hold and bubble-insert signals driven by any number of stall sources. It also sequences multi-cycle front-end flushes and keeps a saturating stall-cycle performance counter and a stall watchdog. It sits beside the pipeline registers and drives their enable/clear controls; the legacy `stall` summary output is kept.

## Interface
- `NUM_SRC`, default 3: number of stall request sources.
- `STAGES`, default 5: pipeline stages, index 0 = fetch … STAGES-1 = writeback.
- `SRC_STAGE`, default {8'd3, 8'd1, 8'd1}: packed NUM_SRC×8 vector; byte i = stage owned by source i (src0/1 = IDU at stage 1, src2 = LD/ST at stage 3). Each value must be < STAGES.
- `FLUSH_DEPTH`, default 2: stages 0..FLUSH_DEPTH-1 are cleared by a flush (1..STAGES).
- `FLUSH_CYCLES`, default 1: length of a flush in cycles (≥1).
- `CNT_W`, default 32: stall counter width.
- `TIMEOUT`, default 1024: consecutive stall cycles before the watchdog fires; 0 disables it.
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `stall_req`  in  NUM_SRC  level stall request per source.
- `flush_req`  in  1  single-cycle flush request (branch/trap redirect).
- `cnt_clr`  in  1  synchronous clear of `stall_cnt` and `timeout_o`.
- `stall_o`  out  STAGES  per-stage hold: the pipeline register of stage s holds when bit s = 1.
- `bubble_o`  out  STAGES  per-stage clear: the register of stage s loads a NOP when bit s = 1.
- `stall`  out  1  OR of `stall_o` (legacy summary).
- `flush_busy`  out  1  flush pending or in progress.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `stall` = 1.
- `timeout_o`  out  1  sticky watchdog flag.

## Operation
- Hold map (combinational, zero latency): `stall_o[s]` = OR of `stall_req[i]` over all i with SRC_STAGE[i] ≥ s. A stall at stage k therefore holds stages 0..k.
- Stall bubble: `bubble_o[s]` = `stall_o[s-1]` & ~`stall_o[s]` for s ≥ 1; `bubble_o[0]` = 0 from stalls.
- Flush bubble: while in state FLUSH, `bubble_o[s]` = 1 for s < FLUSH_DEPTH and `stall_o` for those stages is 0. Stall bubbles on deeper stages are ORed in as usual.
- FSM states: RUN, STALL, FLUSH. `pend` is the flush-pending flag; `fcnt` is the flush down-counter.
  - RUN → STALL when any `stall_req` is set.
  - RUN → FLUSH when `pend` = 1 and no stall; `fcnt` loads FLUSH_CYCLES.
  - STALL → RUN when all requests drop. Go straight to FLUSH instead if `pend` = 1.
  - FLUSH: `fcnt` decrements each cycle. At 1 → RUN, or → STALL if a stall is active.
  - A stall arriving in FLUSH moves to STALL. `fcnt` is retained and the flush resumes afterwards (`pend` stays set).
- `flush_req` sets `pend` at the clock edge. `pend` clears when `fcnt` expires.
  - A `flush_req` during FLUSH reloads `fcnt` to FLUSH_CYCLES.
  - A `flush_req` during STALL only sets `pend`. Stall has priority because the older instruction is held.
- `flush_busy` = `pend` | (state == FLUSH).
- `stall_cnt`: +1 each cycle `stall` = 1; saturates at 2^CNT_W-1. `cnt_clr` has priority over increment.
- Watchdog: `run_cnt` counts consecutive `stall` cycles and resets to 0 when `stall` = 0. `timeout_o` sets when `run_cnt` reaches TIMEOUT and stays set until `cnt_clr` or reset. `run_cnt` saturates at TIMEOUT.
- While `rst_n` = 0, all combinational outputs are forced to 0.

## Timing
- Reset values: state = RUN, `pend` = 0, `fcnt` = 0, `run_cnt` = 0. Outputs: `stall_o` = 0, `bubble_o` = 0, `stall` = 0, `flush_busy` = 0, `stall_cnt` = 0, `timeout_o` = 0.
- Reset asserted mid-flush or mid-stall: the pending flush is dropped and counters are zeroed immediately.
- Stall latency: 0 cycles, request to `stall_o`/`stall`, same as the legacy controller.
- Flush latency: `flush_req` high in cycle t with no stall → `bubble_o[FLUSH_DEPTH-1:0]` high in cycles t+1..t+FLUSH_CYCLES.
- `flush_busy` rises in cycle t+1 and falls in cycle t+FLUSH_CYCLES+1.
- `stall_cnt` and `timeout_o` update one cycle after the qualifying stall cycle.

## Test plan
- Defaults: `stall_req` = 3'b100 for 3 cycles → `stall_o` = 5'b01111, `bubble_o` = 5'b10000, `stall` = 1 each cycle. `stall_cnt` = 3 afterwards.
- `stall_req` = 3'b001 → `stall_o` = 5'b00011, `bubble_o` = 5'b00100. Simultaneous 3'b101 → `stall_o` = 5'b01111.
- FLUSH_CYCLES = 2, `flush_req` pulse at cycle 10, no stall → `bubble_o[1:0]` = 2'b11 in cycles 11–12 and `flush_busy` low from cycle 13.
- `flush_req` while `stall_req[2]` is held for 4 cycles → no flush bubbles during the stall and `flush_busy` = 1. The flush bubbles appear in the first cycle after the stall drops.
- Second `flush_req` in the middle of a 2-cycle flush → `fcnt` reloads and bubbles continue for 2 more cycles.
- TIMEOUT = 8, `stall_req` held for 8 cycles → `timeout_o` = 1 from cycle 9 and stays set after the stall drops. `cnt_clr` → `timeout_o` = 0 and `stall_cnt` = 0 next cycle.
- CNT_W = 4 with 20 stall cycles → `stall_cnt` saturates at 15.
- `rst_n` pulsed low during FLUSH → all outputs 0 immediately and no flush after release.
